// File: rtl/sweep_pkg.sv
// Shared types and defaults for the truth-table sweeper.
// Holds the FSM state encoding and table geometry.
package sweep_pkg;

  localparam int N_IN_DEF   = 4;
  localparam int SETTLE_DEF = 2;
  localparam int DEPTH      = 2**N_IN_DEF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/truth_table_sweeper.sv
// Exhaustive vector sequencer for an N-input combinational block.
// Captures F per vector and grades it against a golden table.
module truth_table_sweeper
  import sweep_pkg::*;
#(
  parameter int N_IN   = N_IN_DEF,
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [2**N_IN-1:0]   expected,
  output logic [N_IN-1:0]      vec,
  input  logic                 f_in,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   table_out,
  output logic                 mismatch,
  output logic [N_IN:0]        fail_count,
  output logic [N_IN-1:0]      first_fail_idx
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(SETTLE - 1);

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic [N_IN-1:0]     r_vec;
  logic                r_busy;
  logic                r_done;
  logic [2**N_IN-1:0]  r_table;
  logic                r_mis;
  logic [N_IN:0]       r_fails;
  logic [N_IN-1:0]     r_first;

  logic                w_miss;
  logic                w_last;

  assign w_miss = f_in ^ expected[r_vec];
  assign w_last = (r_vec == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_vec   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_table <= '0;
      r_mis   <= 1'b0;
      r_fails <= '0;
      r_first <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_vec   <= '0;
            r_cnt   <= RELOAD;
            r_table <= '0;
            r_mis   <= 1'b0;
            r_fails <= '0;
            r_first <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (abort) begin
            r_busy  <= 1'b0;
            r_vec   <= '0;
            r_state <= ST_IDLE;
          end else if (r_cnt == '0) begin
            r_state <= ST_SAMPLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_SAMPLE: begin
          // abort wins over the capture of this vector
          if (abort) begin
            r_busy  <= 1'b0;
            r_vec   <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_table[r_vec] <= f_in;
            if (w_miss) begin
              r_fails <= r_fails + 1'b1;
              r_mis   <= 1'b1;
              if (r_fails == '0) r_first <= r_vec;
            end
            if (w_last) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_vec   <= r_vec + 1'b1;
              r_cnt   <= RELOAD;
              r_state <= ST_WAIT;
            end
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign vec            = r_vec;
  assign busy           = r_busy;
  assign done           = r_done;
  assign table_out      = r_table;
  assign mismatch       = r_mis;
  assign fail_count     = r_fails;
  assign first_fail_idx = r_first;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper with F=(A&B)|(C&D).
// Stimulus pushes expected results; a done-driven monitor grades them.
module tb_truth_table_sweeper;

  localparam int VT = 48;

  typedef struct {
    logic [15:0] tab;
    logic        mis;
    logic [4:0]  cnt;
    logic [3:0]  first;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] expected = '0;
  logic [3:0]  vec;
  logic        f_in;
  logic        busy;
  logic        done;
  logic [15:0] table_out;
  logic        mismatch;
  logic [4:0]  fail_count;
  logic [3:0]  first_fail_idx;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign f_in = (vec[3] & vec[2]) | (vec[1] & vec[0]);

  truth_table_sweeper #(.N_IN(4), .SETTLE(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .abort(abort),
    .expected(expected),
    .vec(vec),
    .f_in(f_in),
    .busy(busy),
    .done(done),
    .table_out(table_out),
    .mismatch(mismatch),
    .fail_count(fail_count),
    .first_fail_idx(first_fail_idx)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (cyc %0d)",
               name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1, want 0 (cyc %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("table_out", 32'(table_out), 32'(e.tab));
        chk("mismatch", 32'(mismatch), 32'(e.mis));
        chk("fail_count", 32'(fail_count), 32'(e.cnt));
        chk("first_fail_idx", 32'(first_fail_idx), 32'(e.first));
        chk("done_cycle", cyc, e.due);
      end
    end
  end

  task automatic push(input logic [15:0] tab, input logic mis,
                      input logic [4:0] cnt, input logic [3:0] ff,
                      input int due);
    exp_t e;
    e.tab = tab; e.mis = mis; e.cnt = cnt;
    e.first = ff; e.due = due;
    sb.push_back(e);
  endtask

  task automatic sweep(input logic [15:0] ex, input logic [15:0] tab,
                       input logic mis, input logic [4:0] cnt,
                       input logic [3:0] ff, input bit mid);
    int k;
    int want;
    expected = ex;
    start = 1'b1;
    k = cyc + 1;
    push(tab, mis, cnt, ff, k + VT);
    @(negedge clk);
    start = 1'b0;
    chk("clear_table", 32'(table_out), 32'h0);
    chk("clear_fails", 32'(fail_count), 32'h0);
    chk("clear_mis", 32'(mismatch), 32'h0);
    for (int j = 0; j <= VT; j++) begin
      want = (j / 3 > 15) ? 15 : j / 3;
      chk("vec_step", 32'(vec), want);
      chk("busy_step", 32'(busy), (j < VT) ? 1 : 0);
      if (mid && j == 10) start = 1'b1;
      if (mid && j == 11) start = 1'b0;
      @(negedge clk);
    end
    @(negedge clk);
    chk("vec_hold", 32'(vec), 32'hF);
  endtask

  initial begin
    int k;
    #1000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_vec", 32'(vec), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_table", 32'(table_out), 0);
    chk("rst_fails", 32'(fail_count), 0);
    rst_n = 1'b1;
    @(negedge clk);

    sweep(16'hF888, 16'hF888, 1'b0, 5'd0,  4'd0,  1'b0);
    sweep(16'hF889, 16'hF888, 1'b1, 5'd1,  4'd0,  1'b1);
    sweep(16'h0777, 16'hF888, 1'b1, 5'd16, 4'd0,  1'b0);
    sweep(16'hF888, 16'hF888, 1'b0, 5'd0,  4'd0,  1'b0);
    sweep(16'hF808, 16'hF888, 1'b1, 5'd1,  4'd7,  1'b0);
    sweep(16'h7888, 16'hF888, 1'b1, 5'd1,  4'd15, 1'b0);

    // start held high: one sweep, DONE, IDLE, then a second sweep
    expected = 16'hF888;
    start = 1'b1;
    k = cyc + 1;
    push(16'hF888, 1'b0, 5'd0, 4'd0, k + VT);
    push(16'hF888, 1'b0, 5'd0, 4'd0, k + 50 + VT);
    while (cyc < k + 49) @(negedge clk);
    chk("held_busy_done", 32'(busy), 0);
    @(negedge clk);
    chk("held_busy_restart", 32'(busy), 1);
    chk("held_vec_restart", 32'(vec), 0);
    start = 1'b0;
    while (cyc < k + 102) @(negedge clk);

    // abort while vec=5 in WAIT
    start = 1'b1;
    k = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < k + 15) @(negedge clk);
    chk("abort_vec_pre", 32'(vec), 5);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_vec", 32'(vec), 0);
    repeat (60) @(negedge clk);
    sweep(16'hF888, 16'hF888, 1'b0, 5'd0, 4'd0, 1'b0);

    // async reset in SAMPLE of vector 9
    expected = 16'h0777;
    start = 1'b1;
    k = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < k + 29) @(negedge clk);
    chk("rst_mid_vec_pre", 32'(vec), 9);
    chk("rst_mid_fails_pre", 32'(fail_count), 9);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_vec", 32'(vec), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_fails", 32'(fail_count), 0);
    chk("rst_mid_mis", 32'(mismatch), 0);
    chk("rst_mid_table", 32'(table_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    sweep(16'hF888, 16'hF888, 1'b0, 5'd0, 4'd0, 1'b0);

    chk("pending_done", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequencer that exhaustively drives every input combination of an N-input combinational function block (for example, a 4-input A/B/C/D -> F logic block).
- Waits a programmable settle time per vector, samples the single-bit output and builds the full truth table.
- Compares the result against an expected table and reports pass/fail, fail count and the first failing index.
- Sits between a control/status interface and the combinational block under test; replaces manual vector stepping.

Parameters:
- N_IN, 4, number of function inputs; table depth = 2**N_IN.
- SETTLE, 2, cycles the vector is held before sampling; legal range >= 1.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a sweep; accepted only in IDLE.
- abort  input  1  cancel an in-progress sweep.
- expected  input  2**N_IN  golden truth table; bit i = expected F for vector i.
- vec  output  N_IN  vector driven to the function inputs; vec[N_IN-1] = A (MSB) ... vec[0] = D.
- f_in  input  1  function output F.
- busy  output  1  high from start acceptance until the final sample.
- done  output  1  one-cycle pulse when the sweep completes.
- table_out  output  2**N_IN  captured F per vector.
- mismatch  output  1  high if any captured bit differs from expected.
- fail_count  output  N_IN+1  number of mismatching vectors (0 .. 2**N_IN).
- first_fail_idx  output  N_IN  lowest failing vector index; 0 when no failure.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - vec, busy, done, table_out, mismatch, fail_count, first_fail_idx all 0.
  - settle counter = 0.
- States: IDLE, WAIT, SAMPLE, DONE.
- IDLE, start=1 at edge k:
  - vec<=0, settle_cnt<=SETTLE-1.
  - table_out, mismatch, fail_count, first_fail_idx cleared to 0.
  - busy<=1, go to WAIT.
- WAIT:
  - vec held stable.
  - settle_cnt==0 -> go to SAMPLE; otherwise decrement.
  - WAIT lasts exactly SETTLE cycles.
- SAMPLE (one cycle):
  - table_out[vec]<=f_in.
  - If f_in != expected[vec]: fail_count+1, mismatch<=1; if this is the first failure, first_fail_idx<=vec.
  - If vec == 2**N_IN-1: busy<=0, go to DONE.
  - Otherwise: vec<=vec+1, reload settle_cnt, go to WAIT.
- Timing:
  - Each vector takes SETTLE+1 cycles.
  - The final SAMPLE edge is k+2**N_IN*(SETTLE+1).
  - done is high in the cycle immediately after that edge, for exactly one cycle; the FSM then returns to IDLE.
- Results (table_out, mismatch, fail_count, first_fail_idx) are held stable from DONE until the next accepted start.
- vec is not incremented past the top: after the last sample it holds 2**N_IN-1 until the next start or reset.
- start while in WAIT, SAMPLE or DONE: ignored; no restart and no queuing.
- abort=1 in WAIT or SAMPLE:
  - Next state is IDLE; busy<=0, vec<=0, no done pulse.
  - Partial results are held; they are not valid.
  - abort has priority over the SAMPLE capture in the same cycle.
- abort in IDLE or DONE: no effect.
- start and abort high together in IDLE: start wins; the sweep begins.
- Async reset mid-sweep: immediate return to the reset values; no done pulse.
- fail_count width N_IN+1, so it never wraps (max 2**N_IN).

Decomposition:
- Package sweep_pkg holds:
  - the state enum (IDLE, WAIT, SAMPLE, DONE);
  - localparam DEPTH = 2**N_IN;
  - the default SETTLE constant.
- No sub-module needed; the FSM, settle counter, vector counter and compare/accumulate logic stay in one module.

Test Plan:
- Golden sweep: N_IN=4, SETTLE=2, F=(A&B)|(C&D), expected=16'hF888, start pulse at edge k -> vec steps 0..15, each held 3 cycles; done at k+48; table_out=16'hF888, mismatch=0, fail_count=0, first_fail_idx=0.
- Single fault: expected=16'hF889 -> mismatch=1, fail_count=1, first_fail_idx=0, table_out=16'hF888.
- All fail: expected=16'h0777 -> fail_count=5'd16 with no wrap; first_fail_idx=0; a second start clears all results before re-accumulating.
- Start hold/ignore: start held high through the whole sweep -> exactly one done pulse at k+48, then a new sweep starts from IDLE; a start pulse during WAIT changes nothing.
- Abort: abort=1 while vec=5 in WAIT -> next cycle busy=0, vec=0, state IDLE, no done pulse; a new start runs a full clean sweep.
- Async reset: rst_n=0 mid-SAMPLE at vec=9 -> all outputs 0 immediately; after release, start gives normal golden-sweep results.
